// File: rtl/hazard_ctrl.sv
// Hazard and data-memory sequencing controller: EX forwarding, load-use stall, branch flush, MEM wait FSM.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic        ResultSrcE0,
  input  logic        PCSrcE,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  input  logic        MemAccessM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteW,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic        mem_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       mem_err_q, mem_err_d;
  logic [7:0] cnt_inc;
  logic       lw_stall;
  logic       mem_stall;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       wr_m,
    input logic [4:0] rd_w,
    input logic       wr_w
  );
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
      return 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
  assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

  // A taken branch squashes the load in EX anyway, so no load-use stall is needed.
  assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    StallF    = lw_stall;
    StallD    = lw_stall;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = PCSrcE;
    FlushE    = lw_stall || PCSrcE;
    FlushW    = 1'b0;

    if (state_q != S_ERR)
      dmem_req = MemAccessM;
    mem_stall = (dmem_req && !dmem_ready) || (state_q == S_ERR);

    case (state_q)
      S_IDLE: begin
        if (mem_stall) begin
          state_d = S_WAIT;
          cnt_d   = 8'd0;
        end
      end
      S_WAIT: begin
        if (dmem_ready) begin
          state_d = S_IDLE;
        end else if (mem_stall) begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_C) begin
            state_d   = S_ERR;
            mem_err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase

    // Memory hold wins: a pending branch or load-use is re-evaluated after release.
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (FlushE && (flush_cnt_q != 32'hFFFF_FFFF))
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: forwarding, load-use, memory wait FSM, timeout and async reset.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        ResultSrcE0, PCSrcE, RegWriteM, MemAccessM, RegWriteW, dmem_ready;
  logic        dmem_req;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
  logic [31:0] stall_cycles, flush_events;

  int checks   = 0;
  int failures = 0;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemAccessM(MemAccessM),
    .RdW(RdW), .RegWriteW(RegWriteW), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  // Packed view of the control outputs: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  function automatic logic [6:0] ctl();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction

  task automatic zero_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE0 = 0; PCSrcE = 0; RegWriteM = 0; MemAccessM = 0;
    RegWriteW = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    zero_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] c;
    do_reset();
    #1;
    c = ctl();
    checks++;
    if ({c, dmem_req, ForwardAE, ForwardBE, mem_err} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs got ctl=%b req=%b fa=%b fb=%b err=%b expected all 0",
               c, dmem_req, ForwardAE, ForwardBE, mem_err);
    end
    checks++;
    if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      failures++;
      $display("FAIL reset_perf got %0d/%0d expected 0/0", stall_cycles, flush_events);
    end
    $display("test_reset done");
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 0;
    #1;
    checks++;
    if (ForwardAE !== 2'b10) begin failures++; $display("FAIL fwd_mem_prio got %b expected 10", ForwardAE); end
    checks++;
    if (ForwardBE !== 2'b00) begin failures++; $display("FAIL fwd_b_x0 got %b expected 00", ForwardBE); end
    RdM = 0;
    #1;
    checks++;
    if (ForwardAE !== 2'b01) begin failures++; $display("FAIL fwd_wb got %b expected 01", ForwardAE); end
    RdW = 0;
    #1;
    checks++;
    if (ForwardAE !== 2'b00) begin failures++; $display("FAIL fwd_none got %b expected 00", ForwardAE); end
    RdM = 7; Rs2E = 7; RdW = 9; Rs1E = 9; RegWriteW = 0;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0010) begin
      failures++; $display("FAIL fwd_b_mem_nowb got a=%b b=%b expected a=00 b=10", ForwardAE, ForwardBE);
    end
    zero_inputs();
    $display("test_forwarding done");
  endtask

  task automatic test_load_use();
    @(negedge clk);
    ResultSrcE0 = 1; RdE = 3; Rs2D = 3;
    #1;
    checks++;
    if (ctl() !== 7'b1100010) begin failures++; $display("FAIL load_use got %b expected 1100010", ctl()); end
    PCSrcE = 1;
    #1;
    checks++;
    if (ctl() !== 7'b0000110) begin failures++; $display("FAIL load_use_branch got %b expected 0000110", ctl()); end
    PCSrcE = 0; RdE = 0; Rs2D = 0;
    #1;
    checks++;
    if (ctl() !== 7'b0000000) begin failures++; $display("FAIL load_x0 got %b expected 0000000", ctl()); end
    zero_inputs();
    $display("test_load_use done");
  endtask

  task automatic test_mem_wait();
    do_reset();
    MemAccessM = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({ctl(), dmem_req} !== 8'b11110011) begin
        failures++; $display("FAIL mem_wait_cycle%0d got %b expected 11110011", i, {ctl(), dmem_req});
      end
      @(negedge clk);
    end
    dmem_ready = 1;
    #1;
    checks++;
    if ({ctl(), dmem_req} !== 8'b00000001) begin
      failures++; $display("FAIL mem_release got %b expected 00000001", {ctl(), dmem_req});
    end
    @(negedge clk);
    zero_inputs();
    checks++;
    if (stall_cycles !== (PERF ? 32'd3 : 32'd0)) begin
      failures++; $display("FAIL stall_cycles got %0d expected %0d", stall_cycles, PERF ? 3 : 0);
    end
    $display("test_mem_wait done");
  endtask

  task automatic test_same_cycle_ready();
    do_reset();
    MemAccessM = 1; dmem_ready = 1;
    #1;
    checks++;
    if ({ctl(), dmem_req} !== 8'b00000001) begin
      failures++; $display("FAIL same_cycle_ready got %b expected 00000001", {ctl(), dmem_req});
    end
    @(negedge clk);
    zero_inputs();
    checks++;
    if (stall_cycles !== 32'd0) begin failures++; $display("FAIL same_cycle_perf got %0d expected 0", stall_cycles); end
    $display("test_same_cycle_ready done");
  endtask

  task automatic test_branch_during_wait();
    do_reset();
    MemAccessM = 1; dmem_ready = 0; PCSrcE = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctl() !== 7'b1111001) begin failures++; $display("FAIL branch_held%0d got %b expected 1111001", i, ctl()); end
      @(negedge clk);
    end
    dmem_ready = 1;
    #1;
    checks++;
    if (ctl() !== 7'b0000110) begin failures++; $display("FAIL branch_release got %b expected 0000110", ctl()); end
    @(negedge clk);
    zero_inputs();
    checks++;
    if (flush_events !== (PERF ? 32'd1 : 32'd0)) begin
      failures++; $display("FAIL flush_events got %0d expected %0d", flush_events, PERF ? 1 : 0);
    end
    $display("test_branch_during_wait done");
  endtask

  // First access waits long, second must start from a cleared counter and not time out after 255 edges.
  task automatic test_back_to_back();
    do_reset();
    MemAccessM = 1; dmem_ready = 0;
    repeat (200) @(negedge clk);
    dmem_ready = 1;
    @(negedge clk);
    dmem_ready = 0;
    #1;
    checks++;
    if (StallF !== 1'b1) begin failures++; $display("FAIL b2b_second_stall got %b expected 1", StallF); end
    repeat (255) @(negedge clk);
    checks++;
    if (mem_err !== 1'b0) begin failures++; $display("FAIL b2b_counter_cleared got mem_err=%b expected 0", mem_err); end
    zero_inputs();
    $display("test_back_to_back done");
  endtask

  task automatic test_timeout();
    do_reset();
    MemAccessM = 1; dmem_ready = 0;
    repeat (255) @(negedge clk);
    checks++;
    if (mem_err !== 1'b0 || dmem_req !== 1'b1) begin
      failures++; $display("FAIL timeout_early got err=%b req=%b expected 0/1", mem_err, dmem_req);
    end
    @(negedge clk);
    checks++;
    if (mem_err !== 1'b1) begin failures++; $display("FAIL timeout_err got %b expected 1", mem_err); end
    @(negedge clk);
    dmem_ready = 1; MemAccessM = 0; PCSrcE = 1;
    #1;
    checks++;
    if ({ctl(), dmem_req} !== 8'b11110010) begin
      failures++; $display("FAIL err_frozen got %b expected 11110010", {ctl(), dmem_req});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (mem_err !== 1'b1 || StallM !== 1'b1) begin
      failures++; $display("FAIL err_sticky got err=%b stallm=%b expected 1/1", mem_err, StallM);
    end
    // Asynchronous reset out of ERR, sampled away from any clock edge.
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_err !== 1'b0 || StallF !== 1'b0 || FlushD !== 1'b1) begin
      failures++; $display("FAIL async_reset_err got err=%b stallf=%b flushd=%b expected 0/0/1", mem_err, StallF, FlushD);
    end
    @(negedge clk);
    reset = 1'b0;
    zero_inputs();
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    MemAccessM = 1; dmem_ready = 0;
    repeat (5) @(negedge clk);
    checks++;
    if (StallE !== 1'b1) begin failures++; $display("FAIL mid_wait_stall got %b expected 1", StallE); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_err !== 1'b0 || stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      failures++; $display("FAIL async_reset_wait got err=%b stall=%0d flush=%0d expected 0/0/0",
                           mem_err, stall_cycles, flush_events);
    end
    @(negedge clk);
    reset = 1'b0;
    MemAccessM = 0;
    #1;
    checks++;
    if (ctl() !== 7'b0000000) begin failures++; $display("FAIL after_reset_idle got %b expected 0000000", ctl()); end
    zero_inputs();
    $display("test_reset_mid_wait done");
  endtask

  initial begin
    reset = 1'b1;
    zero_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_same_cycle_ready();
    test_branch_during_wait();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and data-memory sequencing controller for the five-stage RISC-V core. It generates EX-stage forwarding selects, load-use stalls, and branch flushes. It also runs a small FSM that holds the pipeline while the data memory completes a variable-latency access in the MEM stage. Its stall/flush outputs drive the enable and clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
- MEM_TIMEOUT, 255: maximum WAIT cycles before the error trap; legal range 1..255.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- Rs1D, Rs2D  in  5  source registers of the instruction in ID.
- Rs1E, Rs2E, RdE  in  5  source and destination registers of the instruction in EX.
- ResultSrcE0  in  1  instruction in EX is a load.
- PCSrcE  in  1  taken branch or jump resolved in EX.
- RdM  in  5  destination register in MEM.
- RegWriteM  in  1  MEM instruction writes the register file.
- MemAccessM  in  1  MEM instruction is a load or store.
- RdW  in  5  destination register in WB.
- RegWriteW  in  1  WB instruction writes the register file.
- dmem_ready  in  1  data memory completes the presented access this cycle.
- dmem_req  out  1  data memory access request.
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 10 ALUResultM, 01 ResultW.
- StallF, StallD, StallE, StallM  out  1  hold the PC or pipeline register.
- FlushD, FlushE, FlushW  out  1  clear the IF/ID, ID/EX or MEM/WB register (bubble).
- mem_err  out  1  sticky timeout error.
- stall_cycles  out  32  performance counter.
- flush_events  out  32  performance counter.

## Operation
- Forwarding for Rs1E (same rule for Rs2E):
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Otherwise 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Otherwise 00.
  - MEM has priority over WB.
- Load-use: lwStall = ResultSrcE0 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D) && !PCSrcE.
- Base outputs:
  - StallF = StallD = lwStall.
  - FlushE = lwStall || PCSrcE.
  - FlushD = PCSrcE.
- Memory FSM:
  - States IDLE, WAIT, ERR.
  - dmem_req = MemAccessM in IDLE and WAIT, and 0 in ERR.
  - memStall = dmem_req && !dmem_ready, or state==ERR.
- While memStall:
  - StallF, StallD, StallE and StallM are 1.
  - FlushW = 1.
  - FlushD = FlushE = 0. A pending branch or load-use is re-evaluated after release.
- Transitions:
  - IDLE→WAIT on memStall. The timeout counter is cleared.
  - WAIT→IDLE on dmem_ready. The pipeline is released in that same cycle.
  - WAIT→ERR when the counter reaches MEM_TIMEOUT. mem_err is set.
  - ERR persists until reset and freezes the pipeline permanently.
- Counter: 8 bits, increments each WAIT cycle without dmem_ready.

## Timing
- Forward, stall, flush and dmem_req outputs are combinational from the inputs and the current state; zero-cycle latency.
- The FSM, timeout counter, mem_err and perf counters update on the rising edge of clk.
- Reset values:
  - state IDLE, counter 0, mem_err 0, stall_cycles 0, flush_events 0.
  - With all inputs 0, every combinational output is 0.
- Access completing in the same cycle (dmem_ready=1 in IDLE): no stall, FSM stays in IDLE.
- Reset asserted during WAIT: immediate return to IDLE; the outstanding access is abandoned.
- Back-to-back memory instructions: each begins in IDLE with the counter cleared.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments every cycle StallF=1.
  - flush_events increments every cycle FlushE=1.
  - Both counters saturate at 32'hFFFF_FFFF.
- HAZARD_PERF_CNT_EN undefined: both ports are tied to 0 and no counter flops are built.

## Test plan
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 → ForwardAE=10. With RdM=0 instead → ForwardAE=01. With Rs2E=0, RdW=0 → ForwardBE=00.
- ResultSrcE0=1, RdE=3, Rs2D=3 → StallF=StallD=FlushE=1, FlushD=0. Adding PCSrcE=1 → StallF=0, FlushD=FlushE=1.
- MemAccessM=1, dmem_ready low for 3 cycles then high:
  - Stall* and FlushW are 1 for 3 cycles; state WAIT.
  - On the 4th cycle all stalls are 0 and the state returns to IDLE.
  - With perf enabled, stall_cycles=3.
- MemAccessM=1 with dmem_ready held low for MEM_TIMEOUT+2 cycles → ERR is entered, mem_err=1, dmem_req=0, and the pipeline stays stalled until reset.
- PCSrcE=1 during WAIT → FlushD=FlushE=0 until dmem_ready; on the release cycle FlushD=FlushE=1.
- Reset pulsed mid-WAIT → state IDLE, counters 0, mem_err 0 immediately, without waiting for a clock edge.
